// File: rtl/fp_pkg.sv
// Shared constants, packed-float type and packing helper for the FP multiplier datapath.
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned MANT_W  = 24;
    localparam int unsigned PROD_W  = 48;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    // Internal exponent is 10-bit signed so sums, +1 and rounding carries never wrap.
    localparam int unsigned EXPI_W = 10;
    typedef logic signed [EXPI_W-1:0] exp_int_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    localparam logic [EXP_W-1:0] POS_INF_EXP = 8'hFF;
    localparam fp32_t            FP_ZERO     = '0;
    localparam exp_int_t         EXP_OVF     = exp_int_t'(EXP_MAX);

    function automatic fp32_t pack_float(input logic              sign,
                                         input logic [EXP_W-1:0]  exp,
                                         input logic [FRAC_W-1:0] frac);
        fp32_t f;
        f.sign = sign;
        f.exp  = exp;
        f.frac = frac;
        return f;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational significand rounding; round-to-nearest-even when FP_ROUND_RNE_EN is
// defined, otherwise plain truncation (guard/sticky ignored, no carry path).
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] i_sig,
    input  logic              i_g,
    input  logic              i_s,
    input  exp_int_t          i_exp,
    output logic [MANT_W-1:0] o_sig,
    output exp_int_t          o_exp
);

`ifdef FP_ROUND_RNE_EN
    logic            w_inc;
    logic [MANT_W:0] w_sum;

    assign w_inc = i_g & (i_s | i_sig[0]);
    assign w_sum = {1'b0, i_sig} + {{MANT_W{1'b0}}, w_inc};

    always_comb begin
        o_sig = w_sum[MANT_W-1:0];
        o_exp = i_exp;
        // 0xFFFFFF + 1 renormalizes to 1.0 with the exponent bumped.
        if (w_sum[MANT_W]) begin
            o_sig = {1'b1, {(MANT_W-1){1'b0}}};
            o_exp = i_exp + exp_int_t'(1);
        end
    end
`else
    logic w_unused_gs;

    assign w_unused_gs = i_g ^ i_s;
    assign o_sig       = i_sig;
    assign o_exp       = i_exp;
`endif

endmodule

// File: rtl/fp_mul_normalizer.sv
// Normalize/round/pack stage of the FP32 multiplier: two-stage valid/ready pipeline.
// Rounding mode selected by FP_ROUND_RNE_EN (defined: RNE, undefined: truncate).
module fp_mul_normalizer
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              Signo,
    input  logic [8:0]        Exp_in,
    input  logic [PROD_W-1:0] Mant_prod,
    input  logic              Zero_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       Resultado,
    output logic              Overflow,
    output logic              Underflow
);

    logic w_adv1, w_adv2, w_take;

    // S1 (normalize) signals
    logic [MANT_W-1:0] w_sig_n;
    logic              w_g_n, w_s_n;
    exp_int_t          w_exp_ext, w_exp_n;

    logic              r_v1;
    logic [MANT_W-1:0] r_sig1;
    logic              r_g1, r_s1, r_sign1, r_zero1;
    exp_int_t          r_exp1;

    // S2 (round/pack) signals
    logic [MANT_W-1:0] w_sig_rnd;
    exp_int_t          w_exp_rnd;
    fp32_t             w_res;
    logic              w_ovf, w_unf;
    logic              w_unused_msb;

    logic              r_v2;
    fp32_t             r_res;
    logic              r_ovf, r_unf;

    // No skid buffer: in_ready is combinational from out_ready.
    assign w_adv2   = !r_v2 || out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign in_ready = w_adv1;
    assign w_take   = in_valid && w_adv1;

    assign w_exp_ext = {Exp_in[8], Exp_in};

    always_comb begin
        w_sig_n = Mant_prod[PROD_W-2:MANT_W-1];
        w_g_n   = Mant_prod[MANT_W-2];
        w_s_n   = |Mant_prod[MANT_W-3:0];
        w_exp_n = w_exp_ext;
        if (Mant_prod[PROD_W-1]) begin
            w_sig_n = Mant_prod[PROD_W-1:MANT_W];
            w_g_n   = Mant_prod[MANT_W-1];
            w_s_n   = |Mant_prod[MANT_W-2:0];
            w_exp_n = w_exp_ext + exp_int_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_sig1  <= '0;
            r_g1    <= 1'b0;
            r_s1    <= 1'b0;
            r_exp1  <= '0;
            r_sign1 <= 1'b0;
            r_zero1 <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
            end
            if (w_take) begin
                r_sig1  <= w_sig_n;
                r_g1    <= w_g_n;
                r_s1    <= w_s_n;
                r_exp1  <= w_exp_n;
                r_sign1 <= Signo;
                r_zero1 <= Zero_in;
            end
        end
    end

    fp_round_rne u_round (
        .i_sig (r_sig1),
        .i_g   (r_g1),
        .i_s   (r_s1),
        .i_exp (r_exp1),
        .o_sig (w_sig_rnd),
        .o_exp (w_exp_rnd)
    );

    // Only the hidden bit is dropped when packing.
    assign w_unused_msb = w_sig_rnd[MANT_W-1];

    always_comb begin
        w_res = FP_ZERO;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_zero1) begin
            w_res = pack_float(r_sign1, '0, '0);
        end else if (w_exp_rnd >= EXP_OVF) begin
            w_res = pack_float(r_sign1, POS_INF_EXP, '0);
            w_ovf = 1'b1;
        end else if (w_exp_rnd <= exp_int_t'(0)) begin
            w_res = pack_float(r_sign1, '0, '0);
            w_unf = 1'b1;
        end else begin
            w_res = pack_float(r_sign1, w_exp_rnd[EXP_W-1:0], w_sig_rnd[FRAC_W-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2  <= 1'b0;
            r_res <= FP_ZERO;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_v2 <= r_v1;
            end
            if (w_adv2 && r_v1) begin
                r_res <= w_res;
                r_ovf <= w_ovf;
                r_unf <= w_unf;
            end
        end
    end

    assign out_valid = r_v2;
    assign Resultado = r_res;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;

endmodule

// File: tb/tb_fp_mul_normalizer.sv
// Scoreboard bench for fp_mul_normalizer: directed corner cases, backpressure, reset flush
// and randomized traffic against an arithmetic reference model.
module tb_fp_mul_normalizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        Signo = 1'b0;
    logic [8:0]  Exp_in = '0;
    logic [47:0] Mant_prod = '0;
    logic        Zero_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Resultado;
    logic        Overflow;
    logic        Underflow;

`ifdef FP_ROUND_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } resp_t;

    typedef struct packed {
        logic        s;
        logic [8:0]  e;
        logic [47:0] m;
        logic        z;
    } op_t;

    resp_t sb[$];
    int    checks = 0;
    int    failures = 0;
    int    out_count = 0;
    bit    mon_en = 1'b0;
    bit    rand_bp = 1'b0;

    fp_mul_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Signo     (Signo),
        .Exp_in    (Exp_in),
        .Mant_prod (Mant_prod),
        .Zero_in   (Zero_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Resultado (Resultado),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic s, input logic [8:0] e, input logic [47:0] m,
                               input logic z);
        op_t o;
        o.s = s;
        o.e = e;
        o.m = m;
        o.z = z;
        return o;
    endfunction

    function automatic resp_t rsp(input logic [31:0] res, input logic ovf, input logic unf);
        resp_t r;
        r.res = res;
        r.ovf = ovf;
        r.unf = unf;
        return r;
    endfunction

    // Reference: value-level normalize, round and range check with integer arithmetic.
    function automatic resp_t model(input op_t op);
        resp_t  r;
        longint e, m, sig, rem, half, one;
        int     sh;
        one = 1;
        e   = longint'($signed(op.e));
        m   = longint'({16'h0, op.m});
        if (m >= (one << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        sig  = m >> sh;
        rem  = m - (sig << sh);
        half = one << (sh - 1);
        if (RNE && (rem > half || (rem == half && sig % 2 == 1))) sig = sig + 1;
        if (sig == (one << 24)) begin
            sig = sig / 2;
            e   = e + 1;
        end
        r = '0;
        if (op.z) begin
            r.res = {op.s, 31'b0};
        end else if (e >= 255) begin
            r.res = {op.s, 8'hFF, 23'b0};
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.res = {op.s, 31'b0};
            r.unf = 1'b1;
        end else begin
            r.res = {op.s, 8'(e), 23'(sig)};
        end
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t         o;
        logic [47:0] a, b;
        int          ei;
        a   = {24'h0, 1'b1, 23'($urandom)};
        b   = {24'h0, 1'b1, 23'($urandom)};
        o.m = a * b;
        case ($urandom_range(0, 3))
            0:       ei = int'($urandom_range(0, 511));
            1:       ei = int'($urandom_range(110, 145));
            2:       ei = int'($urandom_range(0, 6)) - 3;
            default: ei = int'($urandom_range(248, 255));
        endcase
        o.e = 9'(ei);
        o.z = ($urandom_range(0, 15) == 0);
        o.s = 1'($urandom);
        return o;
    endfunction

    task automatic drive(input op_t op);
        Signo     = op.s;
        Exp_in    = op.e;
        Mant_prod = op.m;
        Zero_in   = op.z;
        in_valid  = 1'b1;
    endtask

    task automatic send(input op_t op, input resp_t exp);
        int n;
        @(negedge clk);
        drive(op);
        n = 0;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready) begin
            sb.push_back(exp);
            @(posedge clk);
            #1;
        end else begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every presented output is compared with the scoreboard head; popped on transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    check("result", 64'({Resultado, Overflow, Underflow}), 64'(sb[0]));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        out_count++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t bp [4];
        int  k;

        #1 rst_n = 1'b0;
        #2;
        check("reset_outputs", 64'({out_valid, Resultado, Overflow, Underflow}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        mon_en = 1'b1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // Latency: result presented on the second cycle after the transfer.
        send(mk(1'b0, 9'd127, 48'h900000000000, 1'b0), rsp(32'h40100000, 1'b0, 1'b0));
        @(negedge clk);
        #3 check("latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        #3 check("latency_c2", 64'(out_valid), 64'd1);
        drain();

        // Directed corners, back-to-back.
        send(mk(1'b0, 9'd127, 48'h400000000000, 1'b0), rsp(32'h3F800000, 1'b0, 1'b0));
        send(mk(1'b0, 9'd127, 48'h400000400000, 1'b0), rsp(32'h3F800000, 1'b0, 1'b0));
        send(mk(1'b0, 9'd127, 48'h400000C00000, 1'b0),
             rsp(RNE ? 32'h3F800002 : 32'h3F800001, 1'b0, 1'b0));
        send(mk(1'b0, 9'd127, 48'h7FFFFFC00000, 1'b0),
             rsp(RNE ? 32'h40000000 : 32'h3FFFFFFF, 1'b0, 1'b0));
        send(mk(1'b0, 9'd254, 48'h7FFFFFC00000, 1'b0),
             RNE ? rsp(32'h7F800000, 1'b1, 1'b0) : rsp(32'h7F7FFFFF, 1'b0, 1'b0));
        send(mk(1'b1, 9'd255, 48'h400000000000, 1'b0), rsp(32'hFF800000, 1'b1, 1'b0));
        send(mk(1'b0, 9'd254, 48'h800000000000, 1'b0), rsp(32'h7F800000, 1'b1, 1'b0));
        send(mk(1'b1, 9'd0, 48'h400000000000, 1'b0), rsp(32'h80000000, 1'b0, 1'b1));
        send(mk(1'b0, 9'h1F0, 48'h400000000000, 1'b0), rsp(32'h00000000, 1'b0, 1'b1));
        send(mk(1'b0, 9'd1, 48'h400000000000, 1'b0), rsp(32'h00800000, 1'b0, 1'b0));
        send(mk(1'b0, 9'd0, 48'h800000000000, 1'b0), rsp(32'h00800000, 1'b0, 1'b0));
        send(mk(1'b1, 9'h12C, 48'h900000000000, 1'b1), rsp(32'h80000000, 1'b0, 1'b0));
        drain();

        // Backpressure: with the sink stalled only two operations fit.
        for (int i = 0; i < 4; i++) begin
            bp[i]   = rand_op();
            bp[i].z = 1'b0;
            bp[i].e = 9'(120 + i);
        end
        @(negedge clk);
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (k < 4) drive(bp[k]);
            else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready && k < 4) begin
                sb.push_back(model(bp[k]));
                k++;
            end
        end
        check("bp_accepted", 64'(k), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        fork
            begin
                @(negedge clk);
                out_ready = 1'b1;
                for (int c = 0; c < 20 && k < 4; c++) begin
                    if (c > 0) begin
                        @(negedge clk);
                        drive(bp[k]);
                    end
                    #1;
                    if (in_ready) begin
                        sb.push_back(model(bp[k]));
                        k++;
                    end
                end
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    #3 check("bp_stream", 64'({out_valid, out_ready}), 64'd3);
                end
            end
        join
        drain();

        // Randomized traffic with random sink stalls.
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            op_t o;
            o = rand_op();
            send(o, model(o));
        end
        rand_bp = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Asynchronous reset with both stages full.
        @(negedge clk);
        out_ready = 1'b0;
        begin
            op_t o;
            o = mk(1'b1, 9'd130, 48'h900000000000, 1'b0);
            send(o, model(o));
            o = mk(1'b0, 9'd100, 48'h600000000000, 1'b0);
            send(o, model(o));
        end
        @(negedge clk);
        #1 mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 64'({out_valid, Resultado, Overflow, Underflow}), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        mon_en = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #3 check("no_stale_output", 64'(out_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
